// File: rtl/busmux_arbiter.sv
// -----------------------------------------------------------------------------
// busmux_arbiter
//
// Round-robin arbiter that shares a single busmux slave port between NREQ bus
// masters. One requester is granted at a time; its we/addr/data are latched and
// presented to the slave with a one-cycle strobe. The arbiter then waits for the
// slave acknowledge and returns a one-cycle ack (plus read data) to the owner
// only. A hung slave is cut off after TIMEOUT wait cycles with an error ack.
//
// Ports
//   i_clk       clock, all logic on the rising edge
//   i_rst       synchronous active-high reset
//   i_req_stb   per-requester strobe, held until its ack
//   i_req_we    per-requester write enable
//   i_req_addr  requester k address at [8k+7:8k]
//   i_req_data  requester k write data at [DATAW*k +: DATAW]
//   o_req_ack   one-hot one-cycle completion pulse to the owner
//   o_req_err   one-cycle error pulse, coincident with o_req_ack on timeout
//   o_req_data  read data, valid while o_req_ack is high
//   o_grant     one-hot current owner, 0 when idle
//   o_busy      high whenever the arbiter is not idle
//   o_stb       one-cycle strobe to the slave
//   o_we        slave write enable
//   o_addr      slave address
//   o_data      slave write data
//   i_ack       slave acknowledge
//   i_data      slave read data
// -----------------------------------------------------------------------------
module busmux_arbiter #(
  parameter int NREQ    = 2,
  parameter int DATAW   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NREQ-1:0]       i_req_stb,
  input  logic [NREQ-1:0]       i_req_we,
  input  logic [8*NREQ-1:0]     i_req_addr,
  input  logic [DATAW*NREQ-1:0] i_req_data,
  output logic [NREQ-1:0]       o_req_ack,
  output logic [NREQ-1:0]       o_req_err,
  output logic [DATAW-1:0]      o_req_data,
  output logic [NREQ-1:0]       o_grant,
  output logic                  o_busy,
  output logic                  o_stb,
  output logic                  o_we,
  output logic [7:0]            o_addr,
  output logic [DATAW-1:0]      o_data,
  input  logic                  i_ack,
  input  logic [DATAW-1:0]      i_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [IW-1:0]    last_reg, last_next;     // last owner; also the current owner while busy
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [NREQ-1:0]  grant_reg, grant_next;
  logic [NREQ-1:0]  ack_reg, ack_next;
  logic [NREQ-1:0]  err_reg, err_next;
  logic [DATAW-1:0] rdata_reg, rdata_next;
  logic             busy_reg, busy_next;
  logic             stb_reg, stb_next;
  logic             we_reg, we_next;
  logic [7:0]       addr_reg, addr_next;
  logic [DATAW-1:0] wdata_reg, wdata_next;

  // Per-requester views of the packed address/data buses.
  logic [7:0]       req_addr [NREQ];
  logic [DATAW-1:0] req_data [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_addr[gi] = i_req_addr[8*gi +: 8];
    assign req_data[gi] = i_req_data[DATAW*gi +: DATAW];
  end

  // Round-robin pick: scan last+1, last+2, ... (mod NREQ). The loop runs from
  // the farthest candidate to the nearest so the nearest requesting one wins.
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] scan_idx;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      scan_idx = IW'((32'(last_reg) + 32'(k)) % NREQ);
      if (i_req_stb[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    ack_next   = '0;
    err_next   = '0;
    rdata_next = rdata_reg;
    stb_next   = 1'b0;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;

    unique case (state_reg)
      S_IDLE: begin
        if (pick_valid) begin
          state_next = S_ISSUE;
          last_next  = pick_idx;
          grant_next = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          we_next    = i_req_we[pick_idx];
          addr_next  = req_addr[pick_idx];
          wdata_next = req_data[pick_idx];
          stb_next   = 1'b1;
        end
      end

      S_ISSUE: begin
        cnt_next = '0;
        if (i_ack) begin
          // A zero-latency slave completes straight from the strobe cycle.
          state_next = S_DONE;
          rdata_next = i_data;
          ack_next   = grant_reg;
        end else begin
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        // The ack test comes first so a late ack on the last allowed cycle
        // still completes normally.
        if (i_ack) begin
          state_next = S_DONE;
          rdata_next = i_data;
          ack_next   = grant_reg;
        end else if (cnt_reg == CW'(TIMEOUT)) begin
          state_next = S_DONE;
          rdata_next = '0;
          ack_next   = grant_reg;
          err_next   = grant_reg;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
        grant_next = '0;
      end

      default: begin
        state_next = S_IDLE;
        grant_next = '0;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      last_reg  <= IW'(NREQ - 1);
      cnt_reg   <= '0;
      grant_reg <= '0;
      ack_reg   <= '0;
      err_reg   <= '0;
      rdata_reg <= '0;
      busy_reg  <= 1'b0;
      stb_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      rdata_reg <= rdata_next;
      busy_reg  <= busy_next;
      stb_reg   <= stb_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  assign o_req_ack  = ack_reg;
  assign o_req_err  = err_reg;
  assign o_req_data = rdata_reg;
  assign o_grant    = grant_reg;
  assign o_busy     = busy_reg;
  assign o_stb      = stb_reg;
  assign o_we       = we_reg;
  assign o_addr     = addr_reg;
  assign o_data     = wdata_reg;

endmodule

// File: tb/tb_busmux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_busmux_arbiter
//
// Directed bench for busmux_arbiter (NREQ=2, DATAW=8, TIMEOUT=15). Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_busmux_arbiter;

  localparam int NREQ    = 2;
  localparam int DATAW   = 8;
  localparam int TIMEOUT = 15;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_stb;
  logic [NREQ-1:0]       req_we;
  logic [8*NREQ-1:0]     req_addr;
  logic [DATAW*NREQ-1:0] req_data;
  logic [NREQ-1:0]       req_ack;
  logic [NREQ-1:0]       req_err;
  logic [DATAW-1:0]      req_rdata;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  stb;
  logic                  we;
  logic [7:0]            addr;
  logic [DATAW-1:0]      wdata;
  logic                  ack;
  logic [DATAW-1:0]      sdata;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  busmux_arbiter #(.NREQ(NREQ), .DATAW(DATAW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_stb  (req_stb),
    .i_req_we   (req_we),
    .i_req_addr (req_addr),
    .i_req_data (req_data),
    .o_req_ack  (req_ack),
    .o_req_err  (req_err),
    .o_req_data (req_rdata),
    .o_grant    (grant),
    .o_busy     (busy),
    .o_stb      (stb),
    .o_we       (we),
    .o_addr     (addr),
    .o_data     (wdata),
    .i_ack      (ack),
    .i_data     (sdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction from requester k, started in an idle cycle. ack_at is the
  // offset from the o_stb cycle at which the slave pulses i_ack (-1: never).
  // hold marks other requesters that stay requesting without being served.
  task automatic do_xact(input string tag, input int k, input logic w,
                         input logic [7:0] a, input logic [7:0] d,
                         input int ack_at, input logic [7:0] rd,
                         input logic [NREQ-1:0] hold);
    int   lat;
    int   exp_lat;
    bit   seen;
    bit   tmo;
    logic [NREQ-1:0] own;
    own = '0;
    own[k] = 1'b1;
    tmo = (ack_at < 0) || (ack_at > TIMEOUT + 1);
    exp_lat = tmo ? TIMEOUT + 2 : ack_at + 1;
    req_stb = own | hold;
    req_we[k] = w;
    req_addr[8*k +: 8] = a;
    req_data[DATAW*k +: DATAW] = d;
    step();
    chk({tag, "_stb"},   32'(stb),   32'd1);
    chk({tag, "_grant"}, 32'(grant), 32'(own));
    chk({tag, "_we"},    32'(we),    32'(w));
    chk({tag, "_addr"},  32'(addr),  32'(a));
    chk({tag, "_wdata"}, 32'(wdata), 32'(d));
    seen = 1'b0;
    lat = 0;
    for (int off = 0; off < TIMEOUT + 8; off++) begin
      if (req_ack != '0) begin
        seen = 1'b1;
        lat = off;
        break;
      end
      ack = (off == ack_at);
      sdata = (off == ack_at) ? rd : 8'hEE;
      step();
    end
    ack = 1'b0;
    sdata = '0;
    chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_ack"},   32'(req_ack),   32'(own));
    chk({tag, "_err"},   32'(req_err),   tmo ? 32'(own) : 32'd0);
    chk({tag, "_rdata"}, 32'(req_rdata), tmo ? 32'd0 : 32'(rd));
    step();
    req_stb = hold;
    chk({tag, "_ack_clr"}, 32'(req_ack), 32'd0);
    chk({tag, "_idle"},    32'(busy),    32'd0);
    chk({tag, "_gnt_clr"}, 32'(grant),   32'd0);
  endtask

  initial begin
    int   acks;
    int   last_c;
    int   exp_own;
    logic d0, d1, d2;

    rst = 1'b1;
    req_stb = '0;
    req_we = '0;
    req_addr = '0;
    req_data = '0;
    ack = 1'b0;
    sdata = '0;
    step();
    step();
    chk("rst_ack",   32'(req_ack),   32'd0);
    chk("rst_err",   32'(req_err),   32'd0);
    chk("rst_rdata", 32'(req_rdata), 32'd0);
    chk("rst_grant", 32'(grant),     32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_stb",   32'(stb),       32'd0);
    chk("rst_addr",  32'(addr),      32'd0);
    rst = 1'b0;

    // 1: req0 write, slave acks 2 cycles after strobe.
    do_xact("t1_wr0", 0, 1'b1, 8'h12, 8'hA5, 2, 8'h00, 2'b00);
    // 2: req1 read, slave returns 0x3C.
    do_xact("t2_rd1", 1, 1'b0, 8'h21, 8'h00, 2, 8'h3C, 2'b00);

    // 3: both requesters continuously requesting; slave acks 2 cycles after strobe.
    req_stb = 2'b11;
    d0 = 1'b0; d1 = 1'b0; d2 = 1'b0;
    acks = 0;
    last_c = 0;
    exp_own = 0;
    for (int c = 1; c < 40 && acks < 4; c++) begin
      step();
      d2 = d1; d1 = d0; d0 = stb;
      ack = d2;
      sdata = 8'(8'h40 + c);
      if (req_ack != '0) begin
        chk($sformatf("t3_owner%0d", acks), 32'(req_ack), 32'(1 << exp_own));
        if (acks > 0) chk($sformatf("t3_gap%0d", acks), 32'(c - last_c), 32'd5);
        else          chk("t3_first", 32'(c), 32'd4);
        last_c = c;
        exp_own = 1 - exp_own;
        acks++;
        if (acks == 4) req_stb = 2'b00;
      end
    end
    ack = 1'b0;
    chk("t3_ack_count", 32'(acks), 32'd4);
    step();
    chk("t3_idle", 32'(busy), 32'd0);

    // 4: slave never acks -> error termination after TIMEOUT.
    do_xact("t4_tmo", 0, 1'b0, 8'h44, 8'h00, -1, 8'h00, 2'b00);
    // 5: ack coincides with counter==TIMEOUT -> ack wins.
    do_xact("t5_edge", 1, 1'b0, 8'h55, 8'h00, TIMEOUT + 1, 8'h5A, 2'b00);

    // 6: reset in WAIT, stray ack afterwards, then normal service.
    req_stb = 2'b01;
    req_addr[7:0] = 8'h66;
    step();
    chk("t6_stb", 32'(stb), 32'd1);
    step();
    step();
    rst = 1'b1;
    req_stb = 2'b00;
    step();
    rst = 1'b0;
    ack = 1'b1;
    sdata = 8'h99;
    chk("t6_rst_ack",   32'(req_ack), 32'd0);
    chk("t6_rst_busy",  32'(busy),    32'd0);
    chk("t6_rst_grant", 32'(grant),   32'd0);
    chk("t6_rst_addr",  32'(addr),    32'd0);
    step();
    ack = 1'b0;
    sdata = '0;
    chk("t6_stray_ack",  32'(req_ack), 32'd0);
    chk("t6_stray_busy", 32'(busy),    32'd0);
    // Pointer restored: with both requesting, req0 must win; req1 stays pending.
    do_xact("t6_rr0", 0, 1'b0, 8'h70, 8'h00, 2, 8'h11, 2'b10);
    do_xact("t6_wr1", 1, 1'b1, 8'h33, 8'h77, 2, 8'h00, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
